// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer handshake bundle for sync_fifo.
// The master side drives the requests and write data.
// The slave side (the FIFO) returns the read data and the status flags.
interface sync_fifo_if #(
  parameter int FIFO_WIDTH = 32
);
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  full;
  logic                  empty;

  modport master (
    output rd_en,
    output wr_en,
    output data_in,
    input  data_out,
    input  full,
    input  empty
  );

  modport slave (
    input  rd_en,
    input  wr_en,
    input  data_in,
    output data_out,
    output full,
    output empty
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data.
// Pointers carry one extra wrap bit, so full and empty can be told apart.
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds two sticky outputs:
//   overflow  - set when a write is dropped because the FIFO is full.
//   underflow - set when a read is requested while the FIFO is empty.
module sync_fifo #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  output logic          overflow,
  output logic          underflow,
`endif
  sync_fifo_if.slave    bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic full_w, empty_w, rd_accept, wr_accept;

  // Flags come only from the registered pointers, so no input reaches an output.
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A read frees a slot in the same edge, so a full FIFO can still accept a write.
  assign rd_accept = bus.rd_en && !empty_w;
  assign wr_accept = bus.wr_en && (!full_w || rd_accept);

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.data_out = data_out_q;

  // Next-state for the pointers and the read data register.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_accept) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      data_out_d = mem[rd_ptr_q[AW-1:0]];
    end
  end

  // Control state; reset clears it at once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q[AW-1:0]] <= bus.data_in;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; once set, only reset clears them.
  always_comb begin
    overflow_d  = overflow_q  | (bus.wr_en && full_w && !rd_accept);
    underflow_d = underflow_q | (bus.rd_en && empty_w);
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed test of sync_fifo with FIFO_WIDTH=32 and FIFO_DEPTH=8.
// Expected values are hand-computed for each step.
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sync_fifo_if #(.FIFO_WIDTH(32)) bus ();

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow, underflow;
  sync_fifo #(.FIFO_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .overflow(overflow), .underflow(underflow), .bus(bus)
  );
`else
  sync_fifo #(.FIFO_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic we, input logic [31:0] din, input logic re);
    bus.wr_en   = we;
    bus.data_in = din;
    bus.rd_en   = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;

    // Reset asserted between edges (posedges at 5 and 15; assert at 12).
    #12;
    rst = 1'b1;
    #1;
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_dout", bus.data_out, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check("rst_hold_empty", 32'(bus.empty), 32'd1);
    check("rst_hold_full", 32'(bus.full), 32'd0);
    check("rst_hold_dout", bus.data_out, 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
`endif
    rst = 1'b0;

    // Basic write: 10 then 20.
    step(1'b1, 32'd10, 1'b0);
    check("wr1_empty", 32'(bus.empty), 32'd0);
    check("wr1_full", 32'(bus.full), 32'd0);
    check("wr1_dout", bus.data_out, 32'd0);
    step(1'b1, 32'd20, 1'b0);
    check("wr2_empty", 32'(bus.empty), 32'd0);
    check("wr2_full", 32'(bus.full), 32'd0);
    check("wr2_dout", bus.data_out, 32'd0);

    // Basic read for 10 cycles; the last 8 are underflow attempts.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'd0, 1'b1);
      check($sformatf("rd%0d_dout", i), bus.data_out, (i == 0) ? 32'd10 : 32'd20);
      check($sformatf("rd%0d_empty", i), 32'(bus.empty), (i == 0) ? 32'd0 : 32'd1);
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("rd_unf", 32'(underflow), 32'd1);
    check("rd_ovf", 32'(overflow), 32'd0);
`endif

    // Fill with 3 for 10 edges; full after the 8th, the last two writes are dropped.
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 32'd3, 1'b0);
      check($sformatf("fill%0d_full", i), 32'(bus.full), (i >= 8) ? 32'd1 : 32'd0);
      check($sformatf("fill%0d_empty", i), 32'(bus.empty), 32'd0);
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("fill_ovf", 32'(overflow), 32'd1);
`endif
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 32'd0, 1'b1);
      check($sformatf("drain%0d_dout", i), bus.data_out, 32'd3);
      check($sformatf("drain%0d_empty", i), 32'(bus.empty), (i == 8) ? 32'd1 : 32'd0);
      check($sformatf("drain%0d_full", i), 32'(bus.full), 32'd0);
    end

    // Simultaneous read and write while full.
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0);
    check("sf_full_before", 32'(bus.full), 32'd1);
    step(1'b1, 32'hAA, 1'b1);
    check("sf_dout", bus.data_out, 32'd1);
    check("sf_full", 32'(bus.full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 32'd0, 1'b1);
      check($sformatf("sf_rd%0d_dout", i), bus.data_out, (i == 8) ? 32'hAA : 32'(i + 1));
      check($sformatf("sf_rd%0d_empty", i), 32'(bus.empty), (i == 8) ? 32'd1 : 32'd0);
    end

    // Simultaneous read and write while empty: only the write is taken.
    step(1'b1, 32'h55, 1'b1);
    check("se_dout_hold", bus.data_out, 32'hAA);
    check("se_empty", 32'(bus.empty), 32'd0);
    step(1'b0, 32'd0, 1'b1);
    check("se_rd_dout", bus.data_out, 32'h55);
    check("se_rd_empty", 32'(bus.empty), 32'd1);

    // Wrap-around: 20 words at occupancy 3, with overlapped read/write in between.
    for (int k = 0; k < 3; k++) step(1'b1, 32'(k), 1'b0);
    for (int k = 3; k < 20; k++) begin
      step(1'b1, 32'(k), 1'b1);
      check($sformatf("wrap%0d_dout", k), bus.data_out, 32'(k - 3));
      check($sformatf("wrap%0d_empty", k), 32'(bus.empty), 32'd0);
      check($sformatf("wrap%0d_full", k), 32'(bus.full), 32'd0);
    end
    for (int k = 17; k < 20; k++) begin
      step(1'b0, 32'd0, 1'b1);
      check($sformatf("wrapd%0d_dout", k), bus.data_out, 32'(k));
      check($sformatf("wrapd%0d_empty", k), 32'(bus.empty), (k == 19) ? 32'd1 : 32'd0);
    end
    step(1'b0, 32'd0, 1'b1);
    check("wrap_hold_dout", bus.data_out, 32'd19);

    // Mid-operation reset discards contents immediately.
    step(1'b1, 32'h77, 1'b0);
    step(1'b1, 32'h88, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    check("mid_empty_before", 32'(bus.empty), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    check("mid_rst_full", 32'(bus.full), 32'd0);
    check("mid_rst_dout", bus.data_out, 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_unf", 32'(underflow), 32'd0);
`endif
    @(posedge clk); #2;
    rst = 1'b0;
    step(1'b0, 32'd0, 1'b1);
    check("post_rst_rd_dout", bus.data_out, 32'd0);
    check("post_rst_rd_empty", 32'(bus.empty), 32'd1);
    step(1'b1, 32'h99, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    check("post_rst_data", bus.data_out, 32'h99);
    check("post_rst_empty", 32'(bus.empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
